ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/mips_pipe_pkg.sv | 22 ++
 rtl/alu_core.sv | 50 +++++
 rtl/ex_alu_stage.sv | 107 ++++++++++
 tb/tb_ex_alu_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared ALU operation codes and EX-stage request bundle
package mips_pipe_pkg;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;
    localparam logic [4:0] ALU_LU  = 5'b11010;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        reg_write;
    } ex_req_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath; ovf flags signed overflow of ADD/SUB when sign=1
module alu_core
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        alu_ct,
    input  logic              sign,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt;
    logic              is_add;
    logic              is_sub;
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        lt     = sign ? ($signed(a) < $signed(b)) : (a < b);
        is_add = 1'b0;
        is_sub = 1'b0;
        case (alu_ct)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SUB: begin
                result = diff;
                is_sub = 1'b1;
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $signed(b) >>> shamt;
            ALU_LU:  result = {b[15:0], 16'h0000};
            // unassigned codes behave exactly like ADD, including overflow
            default: begin
                result = sum;
                is_add = 1'b1;
            end
        endcase
        ovf = sign && (is_add ? (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1])
                     : is_sub ? (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1])
                     : 1'b0);
    end
endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: one-entry registered ALU stage with valid/ready handshake and flush.
// Define EX_ALU_OVF_TRAP_EN to add out_ovf and suppress reg_write on signed overflow.
module ex_alu_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        alu_ct,
    input  logic              sign,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        shamt,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    input  logic              flush,
`ifdef EX_ALU_OVF_TRAP_EN
    output logic              out_ovf,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [4:0]        out_rd,
    output logic              out_reg_write
);
    ex_req_t           req;
    logic [DATA_W-1:0] alu_result;
    logic              take;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
`ifdef EX_ALU_OVF_TRAP_EN
    logic              alu_ovf;
    logic              ovf_q, ovf_d;
`else
    logic              unused_ovf;
`endif

    assign req = '{a: op_a, b: op_b, shamt: shamt, rd: in_rd, reg_write: in_reg_write};

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .alu_ct (alu_ct),
        .sign   (sign),
        .a      (req.a),
        .b      (req.b),
        .shamt  (req.shamt),
        .result (alu_result),
`ifdef EX_ALU_OVF_TRAP_EN
        .ovf    (alu_ovf)
`else
        .ovf    (unused_ovf)
`endif
    );

    always_comb begin
        in_ready = !valid_q || out_ready;
        // flush wins over capture: the operation accepted this cycle is dropped
        take     = in_valid && in_ready && !flush;
        valid_d  = flush ? 1'b0 : take ? 1'b1 : valid_q && !out_ready;
        result_d = take ? alu_result : result_q;
        zero_d   = take ? (alu_result == '0) : zero_q;
        rd_d     = take ? req.rd : rd_q;
`ifdef EX_ALU_OVF_TRAP_EN
        ovf_d       = take ? alu_ovf : ovf_q;
        reg_write_d = take ? req.reg_write && !alu_ovf : reg_write_q;
`else
        reg_write_d = take ? req.reg_write : reg_write_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
`ifdef EX_ALU_OVF_TRAP_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
`ifdef EX_ALU_OVF_TRAP_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q;
`ifdef EX_ALU_OVF_TRAP_EN
    assign out_ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed and randomized checks of ex_alu_stage against a spec-level model
module tb_ex_alu_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_ct = 5'd0;
    logic        sign = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef EX_ALU_OVF_TRAP_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;
    exp_t pending[$];

    ex_alu_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_ct        (alu_ct),
        .sign          (sign),
        .op_a          (op_a),
        .op_b          (op_b),
        .shamt         (shamt),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
`ifdef EX_ALU_OVF_TRAP_EN
        .out_ovf       (out_ovf),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] c, input logic s,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
        longint sa, sb;
        logic [31:0] r;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        case (c)
            5'b00000: r = a & b;
            5'b00001: r = a | b;
            5'b00110: r = a - b;
            5'b00111: r = (sa < sb) ? 32'd1 : 32'd0;
            5'b01100: r = ~(a | b);
            5'b01101: r = a ^ b;
            5'b10000: r = b * (32'd1 << sh);
            5'b11000: r = b / (32'd1 << sh);
            5'b11001: r = 32'(longint'($signed(b)) >>> sh);
            5'b11010: r = (b & 32'hFFFF) * 32'h10000;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [4:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        alu_ct = c; sign = s; op_a = a; op_b = b; shamt = sh;
        in_rd = 5'($urandom); in_reg_write = 1'b1; in_valid = 1'b1;
    endtask

    task automatic issue(input logic [4:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b0;
        drive(c, s, a, b, sh);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", out_result); end
        checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", out_zero); end
        checks++; if (out_rd !== 5'd0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL reset_rd_rw got=%0d/%b exp=0/0", out_rd, out_reg_write); end
`ifdef EX_ALU_OVF_TRAP_EN
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed;
        issue(5'b00110, 1'b0, 32'd5, 32'd5, 5'd0);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1) begin failures++; $display("FAIL sub_zero got v=%b r=%h z=%b exp v=1 r=0 z=1", out_valid, out_result, out_zero); end
        checks++; if (out_rd !== in_rd || out_reg_write !== 1'b1) begin failures++; $display("FAIL sub_rd got=%0d/%b exp=%0d/1", out_rd, out_reg_write, in_rd); end
        issue(5'b00111, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0);
        checks++; if (out_result !== 32'd1 || out_zero !== 1'b0) begin failures++; $display("FAIL slt_signed got=%h z=%b exp=1 z=0", out_result, out_zero); end
        issue(5'b00111, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0);
        checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL slt_unsigned got=%h exp=0", out_result); end
        issue(5'b11001, 1'b0, 32'd0, 32'h80000000, 5'd4);
        checks++; if (out_result !== 32'hF8000000) begin failures++; $display("FAIL sra got=%h exp=f8000000", out_result); end
        issue(5'b11010, 1'b0, 32'd0, 32'h00001234, 5'd0);
        checks++; if (out_result !== 32'h12340000) begin failures++; $display("FAIL lu got=%h exp=12340000", out_result); end
        issue(5'b11111, 1'b0, 32'd3, 32'd4, 5'd0);
        checks++; if (out_result !== 32'd7) begin failures++; $display("FAIL undef_add got=%h exp=7", out_result); end
        issue(5'b00010, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0);
        checks++; if (out_result !== 32'h80000000) begin failures++; $display("FAIL add_wrap got=%h exp=80000000", out_result); end
`ifdef EX_ALU_OVF_TRAP_EN
        checks++; if (out_ovf !== 1'b1 || out_reg_write !== 1'b0) begin failures++; $display("FAIL ovf_trap got ovf=%b rw=%b exp 1/0", out_ovf, out_reg_write); end
        issue(5'b00010, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd0);
        checks++; if (out_ovf !== 1'b0 || out_reg_write !== 1'b1) begin failures++; $display("FAIL ovf_unsigned got ovf=%b rw=%b exp 0/1", out_ovf, out_reg_write); end
`else
        checks++; if (out_reg_write !== 1'b1) begin failures++; $display("FAIL rw_passthru got=%b exp=1", out_reg_write); end
`endif
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y, z;
        x = $urandom; y = $urandom; z = $urandom;
        @(negedge clk);
        out_ready = 1'b0;
        drive(5'b00010, 1'b0, x, 32'd1, 5'd0);
        @(posedge clk); #1;
        drive(5'b00010, 1'b0, y, 32'd2, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== x + 32'd1) begin failures++; $display("FAIL stall_%0d got rdy=%b v=%b r=%h exp rdy=0 v=1 r=%h", i, in_ready, out_valid, out_result, x + 32'd1); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_result !== y + 32'd2) begin failures++; $display("FAIL b2b_first got v=%b r=%h exp v=1 r=%h", out_valid, out_result, y + 32'd2); end
        drive(5'b00010, 1'b0, z, 32'd3, 5'd0);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_result !== z + 32'd3) begin failures++; $display("FAIL b2b_second got v=%b r=%h exp v=1 r=%h", out_valid, out_result, z + 32'd3); end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        @(negedge clk);
        out_ready = 1'b1;
        drive(5'b00010, 1'b0, 32'd10, 32'd20, 5'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_capture got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_never got=%b exp=0", out_valid); end
        @(negedge clk);
        out_ready = 1'b0;
        drive(5'b00001, 1'b0, 32'd1, 32'd2, 5'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        out_ready = 1'b0;
        drive(5'b01101, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_zero !== 1'b1) begin failures++; $display("FAIL mid_reset got v=%b r=%h z=%b exp v=0 r=0 z=1", out_valid, out_result, out_zero); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_random;
        logic [4:0] codes [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
                                   5'b01101, 5'b10000, 5'b11000, 5'b11001, 5'b11010};
        logic ready_m;
        exp_t e;
        pending.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== (pending.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, pending.size() != 0); end
            if (pending.size() != 0) begin
                checks++;
                if (out_result !== pending[0].result || out_zero !== (pending[0].result == 0) ||
                    out_rd !== pending[0].rd || out_reg_write !== pending[0].rw) begin
                    failures++;
                    $display("FAIL rnd_data[%0d] got r=%h z=%b rd=%0d rw=%b exp r=%h rd=%0d rw=%b", i,
                             out_result, out_zero, out_rd, out_reg_write, pending[0].result, pending[0].rd, pending[0].rw);
                end
            end
            alu_ct = ($urandom_range(0, 5) == 0) ? 5'($urandom) : codes[$urandom_range(0, 10)];
            sign = 1'($urandom);
            op_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            op_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            shamt = 5'($urandom);
            in_rd = 5'($urandom);
            in_reg_write = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            ready_m = (pending.size() == 0) || out_ready;
            #1;
            checks++; if (in_ready !== ready_m) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, ready_m); end
            if (pending.size() != 0 && out_ready) void'(pending.pop_front());
            if (in_valid && ready_m) begin
                e.result = model(alu_ct, sign, op_a, op_b, shamt);
                e.rd = in_rd;
                e.rw = in_reg_write;
`ifdef EX_ALU_OVF_TRAP_EN
                if (sign && (alu_ct == 5'b00110 ?
                        (longint'($signed(op_a)) - longint'($signed(op_b)) != longint'($signed(e.result))) :
                        !(alu_ct inside {5'b00000, 5'b00001, 5'b00111, 5'b01100, 5'b01101,
                                         5'b10000, 5'b11000, 5'b11001, 5'b11010}) &&
                        (longint'($signed(op_a)) + longint'($signed(op_b)) != longint'($signed(e.result)))))
                    e.rw = 1'b0;
`endif
                pending.push_back(e);
            end
            if (flush) pending.delete();
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
